jtgng_snd_cmdq: RTL

Main-CPU-side sound command transmitter, the sending end of the `snd_latch`/`sres_b` interface consumed by the sound subsystem. It queues command bytes written by the main CPU in a small FIFO and presents them one at a time on `snd_latch`. Each byte is held for a programmable number of sound-interrupt periods, counted as V32 falling edges, so the sound Z80 sees every command even when the main CPU writes in bursts. It also owns the sound-CPU reset register that drives `sres_b`.

---
 rtl/jtgng_snd_pkg.sv | 14 +
 rtl/jtgng_snd_fifo.sv | 81 ++++++++
 rtl/jtgng_snd_cmdq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jtgng_snd_pkg.sv
// Shared definitions for the main-CPU sound command queue.
//   cmdq_state_e : command FSM states (IDLE waits for a queued byte,
//                  HOLD keeps the current byte on the sound latch)
//   HOLD_CW      : width of the V32-fall hold counter
package jtgng_snd_pkg;

  typedef enum logic {
    CMDQ_IDLE = 1'b0,
    CMDQ_HOLD = 1'b1
  } cmdq_state_e;

  localparam int unsigned HOLD_CW = 4;

endpackage : jtgng_snd_pkg

// File: rtl/jtgng_snd_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the sound command queue.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the FIFO (pointers and level to zero), wins over push/pop
//   push, din  : write din at the tail; ignored while full
//   pop        : advance the head; ignored while empty
//   dout       : head entry, valid whenever empty is low
//   level      : occupancy 0..2^AW; full/empty decoded from it
module jtgng_snd_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          do_push,  do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop  && !empty && !flush;

  // NOTE: every variable gets its default at the top of the block, so no
  // path through the branches below can leave one unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;   // idle, or push and pop cancel out
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // read after it has been written, and leaving it reset-free lets it map
  // onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : jtgng_snd_fifo

// File: rtl/jtgng_snd_cmdq.sv
// Main-CPU-side sound command transmitter.
// Bytes written by the main CPU are queued and shown one at a time on
// snd_latch, each held for HOLD falling edges of V32 (the sound INT source)
// so the sound Z80 services every command even during write bursts.
//   clk, rst_n          : 24 MHz clock, synchronous active-low reset
//   cen3, V32           : 3 MHz enable and the line-count bit sampled on it
//   cpu_dout            : main CPU write data
//   latch_wr            : push cpu_dout into the queue
//   sres_wr             : load sres_b from cpu_dout[0]
//   ovf_clr             : clear the sticky overflow flag
//   snd_latch, sres_b   : command byte and reset to the sound CPU
//   busy                : a command is being held
//   empty, full, level  : queue status
//   ovf                 : a write was dropped on a full queue
module jtgng_snd_cmdq
  import jtgng_snd_pkg::*;
#(
  parameter int AW        = 3,
  parameter int HOLD      = 2,
  parameter bit CLR_AFTER = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen3,
  input  logic          V32,
  input  logic [7:0]    cpu_dout,
  input  logic          latch_wr,
  input  logic          sres_wr,
  input  logic          ovf_clr,
  output logic [7:0]    snd_latch,
  output logic          sres_b,
  output logic          busy,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam logic [HOLD_CW-1:0] HOLD_INIT = HOLD_CW'(HOLD);

  cmdq_state_e        state_q,    state_d;
  logic [HOLD_CW-1:0] cnt_q,      cnt_d;
  logic [7:0]         latch_q,    latch_d;
  logic               sres_b_q,   sres_b_d;
  logic               ovf_q,      ovf_d;
  logic               last_v32_q, last_v32_d;

  logic               v32_fall;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic [7:0]         fifo_dout;

  // V32 is only looked at on cen3 cycles, so activity between enables is
  // invisible to the hold counter.
  assign v32_fall   = cen3 && last_v32_q && !V32;

  // While the sound CPU is held in reset the queue is kept empty and
  // writes are discarded without touching ovf.
  assign fifo_flush = !sres_b_q;
  assign fifo_push  = latch_wr && sres_b_q;

  jtgng_snd_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cpu_dout),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_d    = latch_q;
    fifo_pop   = 1'b0;
    last_v32_d = cen3 ? V32 : last_v32_q;
    sres_b_d   = sres_wr ? cpu_dout[0] : sres_b_q;

    // A dropped write is judged on the pre-edge full flag, so a pop in the
    // same cycle does not rescue it; clearing wins over setting.
    ovf_d = ovf_q;
    if (ovf_clr)                          ovf_d = 1'b0;
    else if (latch_wr && sres_b_q && full) ovf_d = 1'b1;

    if (!sres_b_q) begin
      state_d = CMDQ_IDLE;
      cnt_d   = '0;
      latch_d = 8'h00;
    end else begin
      case (state_q)
        CMDQ_IDLE: begin
          if (!empty) begin
            fifo_pop = 1'b1;
            latch_d  = fifo_dout;
            cnt_d    = HOLD_INIT;
            state_d  = CMDQ_HOLD;
          end
        end
        CMDQ_HOLD: begin
          if (v32_fall) begin
            cnt_d = cnt_q - HOLD_CW'(1);
            if (cnt_q == HOLD_CW'(1)) begin
              state_d = CMDQ_IDLE;
              if (CLR_AFTER) latch_d = 8'h00;
            end
          end
        end
        default: state_d = CMDQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CMDQ_IDLE;
      cnt_q      <= '0;
      latch_q    <= 8'h00;
      sres_b_q   <= 1'b0;
      ovf_q      <= 1'b0;
      last_v32_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      sres_b_q   <= sres_b_d;
      ovf_q      <= ovf_d;
      last_v32_q <= last_v32_d;
    end
  end

  assign snd_latch = latch_q;
  assign sres_b    = sres_b_q;
  assign busy      = (state_q == CMDQ_HOLD);
  assign ovf       = ovf_q;

endmodule : jtgng_snd_cmdq
